// File: rtl/mem_arb_n.sv
// mem_arb_n: shares one single-port memory between the IFU and the LSU.
// Ports: clk/rst, ifu_req_* / ifu_rsp_* (IFU read channel),
//   lsu_req_* / lsu_rsp_* (LSU read/write channel),
//   mem_* (shared memory port: req/gnt handshake, rvalid response).
module mem_arb_n #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_rdata,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_rdata,
    output logic                lsu_rsp_err,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;
    // cnt can reach TIMEOUT when a grant lands on the last REQ cycle
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    logic               r_owner;
    logic               r_last_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_wen;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [MASK_W-1:0]  r_mem_wmask;
    logic               r_ifu_rsp_valid;
    logic [DATA_W-1:0]  r_ifu_rsp_rdata;
    logic               r_ifu_rsp_err;
    logic               r_lsu_rsp_valid;
    logic [DATA_W-1:0]  r_lsu_rsp_rdata;
    logic               r_lsu_rsp_err;

    logic               w_idle;
    logic               w_gnt_ifu;
    logic               w_gnt_lsu;
    logic               w_timeout;
    logic               w_fin;
    logic               w_fin_err;
    logic [DATA_W-1:0]  w_fin_data;

    assign w_idle    = (r_state == S_IDLE);
    assign w_timeout = (r_cnt >= CNT_W'(TIMEOUT - 1));

    // On conflict the round-robin pick is whoever did not own the last
    // transaction; with RR disabled the LSU always wins.
    always_comb begin
        w_gnt_ifu = 1'b0;
        w_gnt_lsu = 1'b0;
        if (w_idle) begin
            if (ifu_req_valid && lsu_req_valid) begin
                if ((RR_EN != 0) && (r_last_owner == OWN_LSU)) begin
                    w_gnt_ifu = 1'b1;
                end else begin
                    w_gnt_lsu = 1'b1;
                end
            end else begin
                w_gnt_ifu = ifu_req_valid;
                w_gnt_lsu = lsu_req_valid;
            end
        end
    end

    // Transaction completion: a real response in WAIT, otherwise an
    // expired counter in REQ (no grant) or WAIT (no rvalid).
    always_comb begin
        w_fin      = 1'b0;
        w_fin_err  = 1'b1;
        w_fin_data = '0;
        if (r_state == S_WAIT && mem_rvalid) begin
            w_fin      = 1'b1;
            w_fin_err  = 1'b0;
            w_fin_data = r_mem_wen ? '0 : mem_rdata;
        end else if (r_state == S_WAIT && w_timeout) begin
            w_fin = 1'b1;
        end else if (r_state == S_REQ && !mem_gnt && w_timeout) begin
            w_fin = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_owner         <= OWN_IFU;
            r_last_owner    <= OWN_IFU;
            r_cnt           <= '0;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wen       <= 1'b0;
            r_mem_wdata     <= '0;
            r_mem_wmask     <= '0;
            r_ifu_rsp_valid <= 1'b0;
            r_ifu_rsp_rdata <= '0;
            r_ifu_rsp_err   <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;
            r_lsu_rsp_rdata <= '0;
            r_lsu_rsp_err   <= 1'b0;
        end else begin
            r_ifu_rsp_valid <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (w_gnt_lsu) begin
                        r_mem_addr   <= lsu_addr;
                        r_mem_wen    <= lsu_wen;
                        r_mem_wdata  <= lsu_wdata;
                        r_mem_wmask  <= lsu_wmask;
                        r_owner      <= OWN_LSU;
                        r_last_owner <= OWN_LSU;
                        r_cnt        <= '0;
                        r_mem_req    <= 1'b1;
                        r_state      <= S_REQ;
                    end else if (w_gnt_ifu) begin
                        r_mem_addr   <= ifu_addr;
                        r_mem_wen    <= 1'b0;
                        r_mem_wdata  <= '0;
                        r_mem_wmask  <= '0;
                        r_owner      <= OWN_IFU;
                        r_last_owner <= OWN_IFU;
                        r_cnt        <= '0;
                        r_mem_req    <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= r_cnt + 1'b1;
                        r_state   <= S_WAIT;
                    end else if (w_fin) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_fin) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_fin) begin
                if (r_owner == OWN_LSU) begin
                    r_lsu_rsp_valid <= 1'b1;
                    r_lsu_rsp_rdata <= w_fin_data;
                    r_lsu_rsp_err   <= w_fin_err;
                end else begin
                    r_ifu_rsp_valid <= 1'b1;
                    r_ifu_rsp_rdata <= w_fin_data;
                    r_ifu_rsp_err   <= w_fin_err;
                end
            end
        end
    end

    assign ifu_req_ready = w_gnt_ifu;
    assign lsu_req_ready = w_gnt_lsu;
    assign ifu_rsp_valid = r_ifu_rsp_valid;
    assign ifu_rsp_rdata = r_ifu_rsp_rdata;
    assign ifu_rsp_err   = r_ifu_rsp_err;
    assign lsu_rsp_valid = r_lsu_rsp_valid;
    assign lsu_rsp_rdata = r_lsu_rsp_rdata;
    assign lsu_rsp_err   = r_lsu_rsp_err;
    assign mem_req       = r_mem_req;
    assign mem_addr      = r_mem_addr;
    assign mem_wen       = r_mem_wen;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wmask     = r_mem_wmask;

endmodule

// File: tb/tb_mem_arb_n.sv
// tb_mem_arb_n: directed bench for mem_arb_n.
// Two instances: u_a round-robin, u_b fixed priority, both TIMEOUT=8.
module tb_mem_arb_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic [31:0] ifu_addr;
    logic        lsu_req_valid;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        a_ifu_req_ready, a_ifu_rsp_valid, a_ifu_rsp_err;
    logic [31:0] a_ifu_rsp_rdata;
    logic        a_lsu_req_ready, a_lsu_rsp_valid, a_lsu_rsp_err;
    logic [31:0] a_lsu_rsp_rdata;
    logic        a_mem_req, a_mem_wen;
    logic [31:0] a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wmask;

    logic        b_ifu_req_ready, b_ifu_rsp_valid, b_ifu_rsp_err;
    logic [31:0] b_ifu_rsp_rdata;
    logic        b_lsu_req_ready, b_lsu_rsp_valid, b_lsu_rsp_err;
    logic [31:0] b_lsu_rsp_rdata;
    logic        b_mem_req, b_mem_wen;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wmask;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_arb_n #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(8)) u_a (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(a_ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_rsp_valid(a_ifu_rsp_valid),
        .ifu_rsp_rdata(a_ifu_rsp_rdata), .ifu_rsp_err(a_ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(a_lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_rsp_valid(a_lsu_rsp_valid),
        .lsu_rsp_rdata(a_lsu_rsp_rdata), .lsu_rsp_err(a_lsu_rsp_err),
        .mem_req(a_mem_req), .mem_addr(a_mem_addr), .mem_wen(a_mem_wen),
        .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    mem_arb_n #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(8)) u_b (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(b_ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_rsp_valid(b_ifu_rsp_valid),
        .ifu_rsp_rdata(b_ifu_rsp_rdata), .ifu_rsp_err(b_ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(b_lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_rsp_valid(b_lsu_rsp_valid),
        .lsu_rsp_rdata(b_lsu_rsp_rdata), .lsu_rsp_err(b_lsu_rsp_err),
        .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_wen(b_mem_wen),
        .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Minimum-latency IFU read on u_a: accept, gnt, rvalid, response.
    task automatic ifu_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] data);
        ifu_req_valid = 1'b1;
        ifu_addr      = addr;
        mem_gnt       = 1'b1;
        mem_rvalid    = 1'b0;
        #1;
        chk({tag, ".ready"}, a_ifu_req_ready, 1'b1);
        cyc();
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'hFFFF_FFFF;
        #1;
        chk({tag, ".req"}, {a_mem_req, a_mem_addr, a_mem_wen, a_mem_wmask},
            {1'b1, addr, 1'b0, 4'h0});
        cyc();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        #1;
        chk({tag, ".wait"}, {a_mem_req, a_ifu_rsp_valid}, 2'b00);
        cyc();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #1;
        chk({tag, ".rsp"},
            {a_ifu_rsp_valid, a_ifu_rsp_rdata, a_ifu_rsp_err, a_lsu_rsp_valid},
            {1'b1, data, 1'b0, 1'b0});
        cyc();
        chk({tag, ".hold"}, {a_ifu_rsp_valid, a_ifu_rsp_rdata},
            {1'b0, data});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] a_ir, a_lr, b_ir, b_lr, a_iv, a_lv, b_lv;
        logic        seen;
        int          k;

        idle_inputs();
        rst = 1'b1;
        cyc();
        chk("rst.mem",
            {a_mem_req, a_mem_addr, a_mem_wen, a_mem_wdata, a_mem_wmask},
            70'h0);
        chk("rst.rsp",
            {a_ifu_rsp_valid, a_ifu_rsp_err, a_ifu_rsp_rdata,
             a_lsu_rsp_valid, a_lsu_rsp_err, a_lsu_rsp_rdata}, 68'h0);
        rst = 1'b0;
        cyc();

        // 1: plain IFU read
        ifu_read("t1", 32'h8000_0000, 32'h0000_0413);

        // 2/3: both requesters valid from reset, memory always fast
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0040;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h0000_0080;
        mem_gnt       = 1'b1;
        mem_rvalid    = 1'b1;
        mem_rdata     = 32'h1234_5678;
        for (int i = 0; i < 16; i++) begin
            #1;
            a_ir[i] = a_ifu_req_ready;
            a_lr[i] = a_lsu_req_ready;
            b_ir[i] = b_ifu_req_ready;
            b_lr[i] = b_lsu_req_ready;
            a_iv[i] = a_ifu_rsp_valid;
            a_lv[i] = a_lsu_rsp_valid;
            b_lv[i] = b_lsu_rsp_valid;
            cyc();
        end
        chk("t2.lsu_ready", a_lr, 16'h0101);
        chk("t2.ifu_ready", a_ir, 16'h1010);
        chk("t2.lsu_rsp", a_lv, 16'h0808);
        chk("t2.ifu_rsp", a_iv, 16'h8080);
        chk("t3.lsu_ready", b_lr, 16'h1111);
        chk("t3.ifu_ready", b_ir, 16'h0000);
        chk("t3.lsu_rsp", b_lv, 16'h8888);

        // 4: LSU write with grant held off for 3 cycles
        do_reset();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        #1;
        chk("t4.ready", {a_lsu_req_ready, a_ifu_req_ready}, 2'b10);
        cyc();
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wdata     = '0;
        for (int i = 0; i < 4; i++) begin
            mem_gnt = (i == 3);
            #1;
            chk("t4.req",
                {a_mem_req, a_mem_addr, a_mem_wen, a_mem_wdata, a_mem_wmask},
                {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF});
            cyc();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        #1;
        chk("t4.wait", a_mem_req, 1'b0);
        cyc();
        mem_rvalid = 1'b0;
        #1;
        chk("t4.rsp",
            {a_lsu_rsp_valid, a_lsu_rsp_rdata, a_lsu_rsp_err, a_ifu_rsp_valid},
            {1'b1, 32'h0, 1'b0, 1'b0});
        cyc();

        // 5: granted but never answered -> timeout after 8 REQ+WAIT cycles
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0100;
        mem_gnt       = 1'b1;
        mem_rdata     = 32'h5555_5555;
        cyc();
        ifu_req_valid = 1'b0;
        #1;
        chk("t5.req", a_mem_req, 1'b1);
        cyc();
        mem_gnt = 1'b0;
        k = 2;
        while (!a_ifu_rsp_valid && k < 20) begin
            cyc();
            k++;
        end
        chk("t5.latency", k, 9);
        chk("t5.rsp",
            {a_ifu_rsp_valid, a_ifu_rsp_rdata, a_ifu_rsp_err,
             a_mem_req, a_lsu_rsp_valid},
            {1'b1, 32'h0, 1'b1, 1'b0, 1'b0});
        cyc();
        mem_rvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            seen = seen | a_ifu_rsp_valid | a_lsu_rsp_valid;
            cyc();
        end
        mem_rvalid = 1'b0;
        chk("t5.late_rvalid", seen, 1'b0);
        chk("t5.err_hold", a_ifu_rsp_err, 1'b1);

        // 6: reset while waiting for the memory response
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h0000_0200;
        mem_gnt       = 1'b1;
        cyc();
        ifu_req_valid = 1'b0;
        cyc();
        mem_gnt = 1'b0;
        #1;
        chk("t6.in_wait", {a_mem_req, a_mem_addr}, {1'b0, 32'h0000_0200});
        rst = 1'b1;
        cyc();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0077;
        #1;
        chk("t6.after_rst", {a_mem_req, a_mem_addr}, 33'h0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen = seen | a_ifu_rsp_valid | a_lsu_rsp_valid;
            cyc();
            mem_rvalid = 1'b0;
        end
        chk("t6.no_rsp", seen, 1'b0);
        ifu_read("t6", 32'h8000_0004, 32'h0000_0513);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arb_n.md
Name: mem_arb_n

Overview:
Arbiter and sequencer that shares one single-port memory between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multicycle core. It accepts one request at a time via a valid/ready handshake, drives the shared memory port and waits for its response. It then returns a registered response to the owning requester. A timeout guards against a memory that never answers.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
RR_EN, 1, 1 = round-robin between IFU/LSU on conflict; 0 = fixed priority, LSU always wins
TIMEOUT, 255, max cycles in REQ+WAIT before aborting with error (>=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle when valid&&ready
ifu_addr  in  ADDR_W  IFU read address
ifu_rsp_valid  out  1  one-cycle IFU response pulse
ifu_rsp_rdata  out  DATA_W  IFU read data
ifu_rsp_err  out  1  IFU response is a timeout error
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle when valid&&ready
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1 = write, 0 = read
lsu_wdata  in  DATA_W  LSU write data
lsu_wmask  in  DATA_W/8  byte write enables
lsu_rsp_valid  out  1  one-cycle LSU response pulse
lsu_rsp_rdata  out  DATA_W  LSU read data (0 for writes)
lsu_rsp_err  out  1  LSU response is a timeout error
mem_req  out  1  request to memory, held until mem_gnt
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable (0 for IFU)
mem_wdata  out  DATA_W  latched write data
mem_wmask  out  DATA_W/8  latched mask (0 for IFU)
mem_gnt  in  1  memory accepted request (meaningful only while mem_req=1)
mem_rvalid  in  1  memory response/write ack (meaningful only in WAIT)
mem_rdata  in  DATA_W  memory read data, valid with mem_rvalid

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Registers: state, owner (IFU/LSU), last_owner, latched request fields, cnt, response data/err.
- Reset (sync, rst=1 at clock edge): state=IDLE, last_owner=IFU, cnt=0, all rsp_valid/err=0, rsp_rdata=0, mem_req=0, mem_* fields=0. Reset wins over any event, including reset mid-transaction. A pending memory response is then dropped and no rsp pulse is issued.
- IDLE: the ready outputs are combinational and asserted only in IDLE, to at most one requester.
  - Only one valid: grant it.
  - Both valid, RR_EN=1: grant the requester != last_owner.
  - Both valid, RR_EN=0: grant LSU.
  - On grant: latch addr/wen/wdata/wmask (IFU forces wen=0, wmask=0), set owner, set last_owner=owner, cnt=0, then go to REQ.
- REQ: mem_req=1 with latched fields held stable. On mem_gnt go to WAIT. A mem_rvalid in the same cycle as mem_gnt is ignored.
- WAIT: mem_req=0. On mem_rvalid, capture rdata (0 if write) with err=0, then go to RESP.
- Timeout: cnt increments every REQ/WAIT cycle without the exit event. If cnt==TIMEOUT-1 and no exit event, go to RESP with err=1, rdata=0 and mem_req dropped.
- RESP: assert the owner's rsp_valid for exactly this cycle, with rdata/err. The other requester's rsp_valid stays 0. Then go to IDLE.
- rsp_rdata/err hold their value until the next response. There is no response backpressure.
- mem_rvalid outside WAIT (e.g. late after timeout) is ignored.
- Minimum latency, with gnt in the first REQ cycle and rvalid one cycle later: accept at cycle N, rsp_valid at N+3. The next accept is at N+4 at the earliest.
- Requesters must hold valid and fields until ready. Fields are sampled only at the accept edge.

Test Plan:
1. IFU read 0x80000000, gnt immediate, rvalid next cycle with 0x00000413 -> ifu_rsp_valid one cycle at accept+3, rdata 0x00000413, err=0; lsu_rsp_valid stays 0.
2. RR_EN=1, both valid continuously from reset -> grants LSU, IFU, LSU, IFU; each ready pulse lands only in IDLE.
3. RR_EN=0, both valid continuously -> LSU granted every time; ifu_req_ready never asserted.
4. LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_gnt delayed 3 cycles -> mem_req held 4 cycles with stable fields; lsu_rsp_valid with rdata 0, err 0.
5. TIMEOUT=8, gnt given, rvalid never -> owner rsp_valid with err=1, rdata 0, at 8 REQ+WAIT cycles; a later mem_rvalid in IDLE causes no response.
6. rst asserted during WAIT, mem_rvalid on the next cycle -> state IDLE, no rsp pulse, mem_req 0, next IFU request served normally.
